// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
// Write port of the seven-segment scan controller: a new display value
// (BCD nibbles plus per-digit decimal points) offered with valid/ready.
//
// Signals:
//   wr_valid  source -> sink  write request, held until accepted
//   wr_data   source -> sink  4*N_DIG bits of BCD, nibble 0 = rightmost digit
//   wr_dp     source -> sink  N_DIG decimal-point enables
//   wr_ready  sink -> source  sink can take a write this cycle
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
    parameter int N_DIG = 4
);
    logic                 wr_valid;
    logic [4*N_DIG-1:0]   wr_data;
    logic [N_DIG-1:0]     wr_dp;
    logic                 wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_dp,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_dp,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for an N_DIG-digit common-cathode
// seven-segment display. One segment encoder is shared by all digits; each
// digit slot starts with a blanking gap (all selects off) to avoid ghosting.
// Written values are double-buffered and copied to the display register only
// at frame boundaries, so a frame never mixes two values.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   wr           write port (seg_scan_ctrl_if.slave): wr_valid/wr_data/wr_dp in,
//                wr_ready out
//   seg_out      {dp,g,f,e,d,c,b,a}, active-high, registered
//   dig_sel      one-hot digit enable, active-high, zero during blank
//   frame_start  one-cycle pulse when slot 0 of digit 0 begins
//
// Optional build macro:
//   SEG_LEAD_ZERO_BLANK_EN  blank leading zeros (digit index > 0, its nibble and
//                           all higher nibbles zero, its dp off); dig_sel still
//                           asserted for a blanked digit.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int N_DIG     = 4,
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_ctrl_if.slave     wr,
    output logic [7:0]         seg_out,
    output logic [N_DIG-1:0]   dig_sel,
    output logic               frame_start
);
    localparam int CNT_W = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
    localparam int IDX_W = $clog2(N_DIG);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW  = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);
    localparam logic [N_DIG-1:0] DIG_ONE   = N_DIG'(1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 slot_wrap, frame_bnd;

    logic [4*N_DIG-1:0]   disp_data_reg, pend_data_reg;
    logic [N_DIG-1:0]     disp_dp_reg, pend_dp_reg;
    logic                 pend_flag_reg;
    logic                 wr_accept;

    logic [7:0]           seg_next;
    logic [N_DIG-1:0]     dig_next;
    logic                 fs_next;

    logic [3:0]           nib_arr [N_DIG];
    logic [N_DIG-1:0]     lz_blank;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Per-digit views of the display register and the leading-zero mask.
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
        assign nib_arr[gi] = disp_data_reg[4*gi +: 4];
`ifdef SEG_LEAD_ZERO_BLANK_EN
        if (gi == 0) begin : g_first
            assign lz_blank[gi] = 1'b0;
        end else begin : g_upper
            // Blank when this nibble and everything to its left are zero.
            assign lz_blank[gi] = (disp_data_reg[4*N_DIG-1 : 4*gi] == '0) && !disp_dp_reg[gi];
        end
`else
        assign lz_blank[gi] = 1'b0;
`endif
    end

    // Slot counter / digit index sequencing.
    always_comb begin
        slot_wrap = (cnt_reg == CNT_LAST);
        frame_bnd = slot_wrap && (idx_reg == IDX_LAST);
        cnt_next  = slot_wrap ? '0 : cnt_reg + 1'b1;
        idx_next  = idx_reg;
        if (slot_wrap) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    // FSM next state and next (registered) outputs. Outputs are computed from
    // the current state, so the pins trail the state decision by one cycle.
    always_comb begin
        state_next = state_reg;
        dig_next   = '0;
        seg_next   = '0;
        fs_next    = (cnt_reg == '0) && (idx_reg == '0);
        case (state_reg)
            ST_BLANK: begin
                if (cnt_next == CNT_SHOW) begin
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                dig_next = DIG_ONE << idx_reg;
                if (!lz_blank[idx_reg]) begin
                    seg_next = {disp_dp_reg[idx_reg], seg_encode(nib_arr[idx_reg])};
                end
                if (slot_wrap) begin
                    state_next = ST_BLANK;
                end
            end
            default: state_next = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_BLANK;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            seg_out     <= '0;
            dig_sel     <= '0;
            frame_start <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            seg_out     <= seg_next;
            dig_sel     <= dig_next;
            frame_start <= fs_next;
        end
    end

    // Double buffer: ready is simply "no pending value", so an accept and a
    // frame-boundary transfer can never happen in the same cycle.
    assign wr.wr_ready = !pend_flag_reg;
    assign wr_accept   = wr.wr_valid && !pend_flag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data_reg <= '0;
            disp_dp_reg   <= '0;
            pend_data_reg <= '0;
            pend_dp_reg   <= '0;
            pend_flag_reg <= 1'b0;
        end else if (frame_bnd && pend_flag_reg) begin
            disp_data_reg <= pend_data_reg;
            disp_dp_reg   <= pend_dp_reg;
            pend_flag_reg <= 1'b0;
        end else if (wr_accept) begin
            pend_data_reg <= wr.wr_data;
            pend_dp_reg   <= wr.wr_dp;
            pend_flag_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Bench for seg_scan_ctrl with N_DIG=4, SLOT_CYC=8, BLANK_CYC=2 (32-cycle
// frame). The reference model works in frame arithmetic: it counts cycles since
// reset release, derives slot position / digit from that count, and swaps the
// displayed value at every 32-cycle boundary when a write is pending.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;
    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * SLOT;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg_out;
    logic [3:0] dig_sel;
    logic       frame_start;

    seg_scan_ctrl_if #(.N_DIG(N)) wr_if ();

    seg_scan_ctrl #(.N_DIG(N), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr_if),
        .seg_out     (seg_out),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_cnt;       // rising edges since reset release
    logic        m_pend;
    logic [15:0] m_pval, m_val, m_out_val;
    logic [3:0]  m_pdp, m_dp, m_out_dp;
    logic        m_acc;       // a write was accepted at the last edge

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_pend <= 1'b0; m_acc <= 1'b0;
            m_pval <= '0; m_pdp <= '0; m_val <= '0; m_dp <= '0;
            m_out_val <= '0; m_out_dp <= '0;
        end else begin
            m_cnt     <= m_cnt + 1;
            m_out_val <= m_val;
            m_out_dp  <= m_dp;
            m_acc     <= wr_if.wr_valid && !m_pend;
            if (((m_cnt + 1) % FRAME) == 0 && m_pend) begin
                m_val  <= m_pval;
                m_dp   <= m_pdp;
                m_pend <= 1'b0;
            end
            if (wr_if.wr_valid && !m_pend) begin
                m_pend <= 1'b1;
                m_pval <= wr_if.wr_data;
                m_pdp  <= wr_if.wr_dp;
            end
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
            4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
            4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
            4'd9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    // Expected {frame_start, wr_ready, dig_sel, seg_out} after the latest edge.
    function automatic logic [13:0] exp_vec();
        int p, pos, d;
        logic [3:0] dig;
        logic [7:0] seg;
        if (m_cnt == 0) return {1'b0, !m_pend, 4'b0, 8'h00};
        p   = m_cnt - 1;
        pos = p % SLOT;
        d   = (p / SLOT) % N;
        dig = '0;
        seg = '0;
        if (pos >= BLANK) begin
            dig = 4'(1 << d);
            seg = {m_out_dp[d], enc(m_out_val[4*d +: 4])};
`ifdef SEG_LEAD_ZERO_BLANK_EN
            if (d != 0 && !m_out_dp[d] && (m_out_val >> (4*d)) == 16'h0) seg = 8'h00;
`endif
        end
        return {(p % FRAME) == 0, !m_pend, dig, seg};
    endfunction

    function automatic int fpos();
        return (m_cnt == 0) ? -1 : (m_cnt - 1) % FRAME;
    endfunction

    logic [13:0] got, exp;

    task automatic test_reset();
        rst_n = 1'b0;
        wr_if.wr_valid = 1'b0; wr_if.wr_data = '0; wr_if.wr_dp = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_hold cyc=%0d got=%h want=%h", c, got, exp); end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_scan cyc=%0d got=%h want=%h", c, got, exp); end
        end
        $display("reset: %0d cycles scanned after release", 2 * FRAME);
    endtask

    task automatic test_write_apply();
        bit started = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
            if (got !== exp) begin errors++; $display("FAIL write_apply cyc=%0d got=%h want=%h", c, got, exp); end
            if (m_out_val == 16'h1234 && exp[11:8] == 4'b0100) begin
                checks++;
                if (seg_out !== 8'hDB) begin errors++; $display("FAIL write_apply_dp seg=%h want=db", seg_out); end
            end
            if (m_acc) wr_if.wr_valid = 1'b0;
            if (!started && fpos() == 12) begin
                wr_if.wr_valid = 1'b1; wr_if.wr_data = 16'h1234; wr_if.wr_dp = 4'b0100; started = 1;
                $display("write_apply: wr_data=1234 wr_dp=0100");
            end
        end
    endtask

    task automatic test_backpressure();
        int stage = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
            if (got !== exp) begin errors++; $display("FAIL backpressure cyc=%0d got=%h want=%h", c, got, exp); end
            if (m_out_val == 16'h9999 && exp[11:8] != 4'b0) begin
                checks++;
                if (seg_out !== 8'h6F) begin errors++; $display("FAIL backpressure_9 seg=%h want=6f", seg_out); end
            end
            if (m_acc && stage == 1) begin
                wr_if.wr_data = 16'h9999; wr_if.wr_dp = 4'b0000; stage = 2;   // held while not ready
                $display("backpressure: 5678 accepted, holding 9999");
            end else if (m_acc && stage == 2) begin
                wr_if.wr_valid = 1'b0; stage = 3;
                $display("backpressure: 9999 accepted");
            end
            if (stage == 0 && fpos() == 12) begin
                wr_if.wr_valid = 1'b1; wr_if.wr_data = 16'h5678; wr_if.wr_dp = 4'b0001; stage = 1;
            end
        end
    endtask

    task automatic test_invalid_code();
        bit started = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
            if (got !== exp) begin errors++; $display("FAIL invalid_code cyc=%0d got=%h want=%h", c, got, exp); end
            if (m_out_val == 16'hFA05 && exp[11:8] == 4'b0001) begin
                checks++;
                if (seg_out !== 8'h6D) begin errors++; $display("FAIL invalid_code_d0 seg=%h want=6d", seg_out); end
            end
            if (m_out_val == 16'hFA05 && exp[11:8] == 4'b1000) begin
                checks++;
                if (seg_out !== 8'h00) begin errors++; $display("FAIL invalid_code_d3 seg=%h want=00", seg_out); end
            end
            if (m_acc) wr_if.wr_valid = 1'b0;
            if (!started && fpos() == 5) begin
                wr_if.wr_valid = 1'b1; wr_if.wr_data = 16'hFA05; wr_if.wr_dp = 4'b0000; started = 1;
                $display("invalid_code: wr_data=fa05");
            end
        end
    endtask

    task automatic test_leading_zero();
        int stage = 0;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
            if (got !== exp) begin errors++; $display("FAIL leading_zero cyc=%0d got=%h want=%h", c, got, exp); end
            if (m_out_val == 16'h0042 && exp[11:8] == 4'b0001) begin
                checks++;
                if (seg_out !== 8'h5B) begin errors++; $display("FAIL leading_zero_d0 seg=%h want=5b", seg_out); end
            end
            if (m_acc && stage == 1) begin
                wr_if.wr_data = 16'h0000; stage = 2;
            end else if (m_acc && stage == 2) begin
                wr_if.wr_valid = 1'b0; stage = 3;
            end
            if (stage == 0 && fpos() == 3) begin
                wr_if.wr_valid = 1'b1; wr_if.wr_data = 16'h0042; wr_if.wr_dp = 4'b0000; stage = 1;
                $display("leading_zero: writes 0042 then 0000");
            end
        end
    endtask

    task automatic test_random();
        int n_wr = 0;
        for (int c = 0; c < 320; c++) begin
            @(negedge clk);
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
            if (got !== exp) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", c, got, exp); end
            if (m_acc) wr_if.wr_valid = 1'b0;
            if (!wr_if.wr_valid && c < 200 && $urandom_range(0, 3) == 0) begin
                wr_if.wr_valid = 1'b1; wr_if.wr_data = 16'($urandom); wr_if.wr_dp = 4'($urandom);
                n_wr++;
                $display("random: write %0d data=%h dp=%b", n_wr, wr_if.wr_data, wr_if.wr_dp);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit started = 0, hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", c, got, exp); end
            if (m_acc) wr_if.wr_valid = 1'b0;
            if (started && m_pend && exp[11:8] == 4'b0100) begin
                hit = 1;
            end else if (!started && !m_pend && !wr_if.wr_valid && fpos() == 1) begin
                wr_if.wr_valid = 1'b1; wr_if.wr_data = 16'h7777; wr_if.wr_dp = 4'b1111; started = 1;
            end
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL reset_mid_reach hit=%0d want=1", hit);
        end else begin
            rst_n = 1'b0;
            #1;
            checks++;
            got = {frame_start, wr_if.wr_ready, dig_sel, seg_out};
            if (got !== {1'b0, 1'b1, 4'b0, 8'h00}) begin
                errors++; $display("FAIL reset_mid_async got=%h want=%h", got, {1'b0, 1'b1, 4'b0, 8'h00});
            end
            $display("reset_mid: reset asserted during digit 2 with write pending");
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 2 * FRAME + 4; c++) begin
                @(negedge clk);
                got = {frame_start, wr_if.wr_ready, dig_sel, seg_out}; exp = exp_vec(); checks++;
                if (got !== exp) begin errors++; $display("FAIL reset_mid_post cyc=%0d got=%h want=%h", c, got, exp); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_apply();
        test_backpressure();
        test_invalid_code();
        test_leading_zero();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
